// File: rtl/wb_grf.sv
// Write-back register file (32x32) with W->D bypass and a first-word-fall-through
// commit-trace FIFO drained over a valid/ready handshake.
package wb_grf_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;
    localparam int unsigned NREG = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RAW-1:0]  a3;
        logic [XLEN-1:0] wd;
    } trace_entry_t;
endpackage

module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned TRACE_AW    = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                WEnW,
    input  logic [RAW-1:0]      A3W,
    input  logic [XLEN-1:0]     WDW,
    input  logic [XLEN-1:0]     PCW,
    input  logic [RAW-1:0]      RA1,
    input  logic [RAW-1:0]      RA2,
    output logic [XLEN-1:0]     RD1,
    output logic [XLEN-1:0]     RD2,
    output logic                TrcValid,
    input  logic                TrcReady,
    output logic [XLEN-1:0]     TrcPC,
    output logic [RAW-1:0]      TrcA3,
    output logic [XLEN-1:0]     TrcWD,
    output logic [TRACE_AW:0]   TrcCount,
    output logic                TrcOverflow
);
    localparam int unsigned CW = TRACE_AW + 1;

    logic [XLEN-1:0]     regs_q [NREG];
    logic [XLEN-1:0]     regs_d [NREG];
    trace_entry_t        mem_q  [TRACE_DEPTH];
    trace_entry_t        mem_d  [TRACE_DEPTH];
    logic [TRACE_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TRACE_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic         commit, pop, full, push;
    trace_entry_t head;

    // A write to $0 is not a commit; reset suppresses commits outright.
    assign commit = WEnW && (A3W != '0) && !Reset;
    assign pop    = (count_q != '0) && TrcReady;
    assign full   = (count_q == CW'(TRACE_DEPTH));
    assign push   = commit && (!full || pop);

    always_comb begin
        regs_d   = regs_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (commit) begin
            regs_d[A3W] = WDW;
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: PCW, a3: A3W, wd: WDW};
            wr_ptr_d        = wr_ptr_q + TRACE_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + TRACE_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A full FIFO without a concurrent pop drops the entry and flags it.
        if (commit && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Trace storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign RD1 = (Reset || RA1 == '0)       ? '0  :
                 (commit && A3W == RA1)     ? WDW : regs_q[RA1];
    assign RD2 = (Reset || RA2 == '0)       ? '0  :
                 (commit && A3W == RA2)     ? WDW : regs_q[RA2];

    assign TrcValid    = (count_q != '0);
    assign head        = TrcValid ? mem_q[rd_ptr_q] : '0;
    assign TrcPC       = head.pc;
    assign TrcA3       = head.a3;
    assign TrcWD       = head.wd;
    assign TrcCount    = count_q;
    assign TrcOverflow = ovf_q;
endmodule
